// File: rtl/serial_rx_pkg.sv
// ============================================================================
// Module   : serial_rx_pkg
// Brief    : Shared FSM state encoding and default sizes for serial_word_rx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_rx_pkg;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_SHIFT = 2'd1,
      RX_PAR   = 2'd2,
      RX_PUSH  = 2'd3
   } rx_state_e;

   localparam int RX_WIDTH_DEF = 4;
   localparam int RX_DEPTH_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/rx_word_fifo.sv
// ============================================================================
// Module   : rx_word_fifo
// Brief    : Synchronous FIFO, pointers one bit wider than the address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_word_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic             o_full,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_full;
   logic             w_empty;
   logic             w_wr;
   logic             w_rd;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // A write into a full FIFO is still taken when a read frees a slot on the same edge.
   assign w_rd = i_rd_en && !w_empty;
   assign w_wr = i_wr_en && (!w_full || w_rd);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
   end

   assign o_full    = w_full;
   assign o_empty   = w_empty;
   assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/serial_word_rx.sv
// ============================================================================
// Module   : serial_word_rx
// Brief    : Serial MSB-first frame receiver with output FIFO and valid/ready.
//            Optional even-parity check enabled by macro RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_word_rx
   import serial_rx_pkg::*;
#(
   parameter int WIDTH = RX_WIDTH_DEF,
   parameter int DEPTH = RX_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             D,
   input  logic             CS,
   input  logic             sof,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             busy,
   output logic             overflow,
   output logic             parity_err
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE  = RX_IDLE;
   localparam logic [1:0] S_SHIFT = RX_SHIFT;
   localparam logic [1:0] S_PUSH  = RX_PUSH;
`ifdef RX_PARITY_EN
   localparam logic [1:0] S_PAR   = RX_PAR;
   localparam logic [1:0] S_DONE  = S_PAR;
`else
   localparam logic [1:0] S_DONE  = S_PUSH;
`endif

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    r_bitcnt;
   logic             r_ovf;
   logic             r_par_err;

   logic [WIDTH-1:0] w_shift;
   logic [CW-1:0]    w_cnt_inc;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_start;

   assign w_shift   = (r_shreg << 1) | WIDTH'(D);
   assign w_cnt_inc = r_bitcnt + CW'(1);
   assign w_push    = (r_state == S_PUSH);
   assign w_pop     = !w_empty && word_ready;
   // sof restarts a frame from any state except the fixed PUSH cycle
   assign w_start   = CS && sof && (r_state != S_PUSH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_shreg   <= '0;
         r_bitcnt  <= '0;
         r_ovf     <= 1'b0;
         r_par_err <= 1'b0;
      end else begin
         r_par_err <= 1'b0;
         r_ovf     <= r_ovf | (w_push & w_full & ~w_pop);
         if (w_start) begin
            r_shreg  <= WIDTH'(D);
            r_bitcnt <= CW'(1);
            r_state  <= (WIDTH == 1) ? S_DONE : S_SHIFT;
         end else begin
            case (r_state)
               S_IDLE: ;
               S_SHIFT: begin
                  if (CS) begin
                     r_shreg  <= w_shift;
                     r_bitcnt <= w_cnt_inc;
                     if (w_cnt_inc == CW'(WIDTH)) r_state <= S_DONE;
                  end
               end
`ifdef RX_PARITY_EN
               S_PAR: begin
                  if (CS) begin
                     if (^{r_shreg, D}) begin
                        r_par_err <= 1'b1;
                        r_bitcnt  <= '0;
                        r_state   <= S_IDLE;
                     end else begin
                        r_state   <= S_PUSH;
                     end
                  end
               end
`endif
               S_PUSH: begin
                  r_bitcnt <= '0;
                  r_state  <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   rx_word_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_push),
      .i_wr_data (r_shreg),
      .o_full    (w_full),
      .i_rd_en   (word_ready),
      .o_rd_data (word_out),
      .o_empty   (w_empty)
   );

   assign word_valid = !w_empty;
   assign busy       = (r_state != S_IDLE);
   assign overflow   = r_ovf;
   assign parity_err = r_par_err;

endmodule

`default_nettype wire

// File: tb/tb_serial_word_rx.sv
// ============================================================================
// Module   : tb_serial_word_rx
// Brief    : Self-checking bench for serial_word_rx (honours RX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_word_rx;

   localparam int W     = 4;
   localparam int DEPTH = 4;
`ifdef RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         D, CS, sof, word_ready;
   logic [W-1:0] word_out;
   logic         word_valid, busy, overflow, parity_err;

   serial_word_rx #(.WIDTH(W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .D          (D),
      .CS         (CS),
      .sof        (sof),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .busy       (busy),
      .overflow   (overflow),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: frame-level view of the receiver plus a word queue.
   logic [W-1:0] m_q[$];
   logic         m_pend_v;
   logic [W-1:0] m_pend_w;
   logic         m_inprog;
   logic         m_ovf;
   logic         m_perr;
   int           mode;   // 0: ready low, 1: ready high, 2: random ready

   typedef struct {
      logic [W-1:0] bits;   // data bits, MSB sent first
      int           gap;    // idle CS=0 cycles between bits
      logic [W-1:0] exp;
   } vec_t;
   vec_t tbl[5];

   function automatic logic rbit();
      logic [31:0] t;
      t = $urandom;
      return t[0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: check outputs, drive inputs, advance the model across the edge.
   task automatic cyc(input logic d, input logic cs, input logic s, input int kind,
                      input logic [W-1:0] w);
      logic rdy;
      chk("word_valid", 32'(word_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("word_out", 32'(word_out), 32'(m_q[0]));
      chk("busy", 32'(busy), 32'(m_inprog || m_pend_v));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("parity_err", 32'(parity_err), 32'(m_perr));
      case (mode)
         0:       rdy = 1'b0;
         1:       rdy = 1'b1;
         default: rdy = rbit();
      endcase
      D = d; CS = cs; sof = s; word_ready = rdy;
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      if (m_pend_v) begin
         if (m_q.size() < DEPTH) m_q.push_back(m_pend_w);
         else                    m_ovf = 1'b1;
      end
      m_pend_v = 1'b0;
      m_perr   = 1'b0;
      case (kind)
         1: m_inprog = 1'b1;
         2: begin m_inprog = 1'b0; m_pend_v = 1'b1; m_pend_w = w; end
         3: begin m_inprog = 1'b0; m_perr = 1'b1; end
         default: ;
      endcase
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(rbit(), 1'b0, rbit(), 0, '0);
   endtask

   task automatic send_frame(input logic [W-1:0] w, input int gap, input bit bad);
      logic [W:0] bits;
      int         nb;
      int         kind;
      nb   = W + PB;
      bits = {w, (^w) ^ bad};
      for (int i = 0; i < nb; i++) begin
         kind = (i == nb - 1) ? (bad ? 3 : 2) : 1;
         cyc(bits[W-i], 1'b1, (i == 0), kind, w);
         if (i != nb - 1) for (int g = 0; g < gap; g++) cyc(rbit(), 1'b0, rbit(), 0, '0);
      end
   endtask

   task automatic abort_bits(input int n);
      for (int i = 0; i < n; i++) cyc(rbit(), 1'b1, (i == 0), 1, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; CS = 1'b0; sof = 1'b0; D = 1'b0; word_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_q.delete();
      m_pend_v = 1'b0; m_pend_w = '0; m_inprog = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_valid"},   32'(word_valid), 32'd0);
      chk({tag, "_word"},    32'(word_out),   32'd0);
      chk({tag, "_busy"},    32'(busy),       32'd0);
      chk({tag, "_ovf"},     32'(overflow),   32'd0);
      chk({tag, "_par_err"}, 32'(parity_err), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] t;
      logic [W-1:0] rw;
      bit bad;

      tbl[0] = '{bits: 4'b1101, gap: 0, exp: 4'hD};
      tbl[1] = '{bits: 4'b0010, gap: 2, exp: 4'h2};
      tbl[2] = '{bits: 4'b0000, gap: 1, exp: 4'h0};
      tbl[3] = '{bits: 4'b1111, gap: 0, exp: 4'hF};
      tbl[4] = '{bits: 4'b1001, gap: 3, exp: 4'h9};

      mode = 0;
      rst_n = 1'b0; D = 1'b0; CS = 1'b0; sof = 1'b0; word_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      do_reset();
      chk_reset_state("reset");

      // Table-driven single frames, one gap cycle, then pop.
      for (int i = 0; i < 5; i++) begin
         mode = 0;
         send_frame(tbl[i].bits, tbl[i].gap, 1'b0);
         chk("tbl_push_cycle_valid", 32'(word_valid), 32'd0);
         idle(1);
         chk("tbl_word", 32'(word_out), 32'(tbl[i].exp));
         chk("tbl_valid", 32'(word_valid), 32'd1);
         chk("tbl_busy", 32'(busy), 32'd0);
         mode = 1;
         idle(1);
         chk("tbl_popped", 32'(word_valid), 32'd0);
      end

      // Mid-frame restart: 1,0 then a fresh frame 0,1,1,0.
      mode = 0;
      cyc(1'b1, 1'b1, 1'b1, 1, '0);
      cyc(1'b0, 1'b1, 1'b0, 1, '0);
      send_frame(4'h6, 0, 1'b0);
      idle(1);
      chk("restart_word", 32'(word_out), 32'h6);
      mode = 1;
      idle(1);
      chk("restart_single", 32'(word_valid), 32'd0);

      // Push into a full FIFO while the consumer pops on the same edge.
      mode = 0;
      for (int v = 7; v <= 10; v++) begin
         send_frame(W'(v), 0, 1'b0);
         idle(1);
      end
      send_frame(4'hB, 0, 1'b0);
      mode = 1;
      idle(1);
      for (int v = 8; v <= 11; v++) begin
         chk("samepop_order", 32'(word_out), 32'(v));
         idle(1);
      end
      chk("samepop_no_ovf", 32'(overflow), 32'd0);

      // Backpressure and overflow.
      mode = 0;
      for (int v = 1; v <= 5; v++) begin
         send_frame(W'(v), 0, 1'b0);
         idle(1);
      end
      chk("ovf_set", 32'(overflow), 32'd1);
      mode = 1;
      for (int v = 1; v <= 4; v++) begin
         chk("ovf_pop_order", 32'(word_out), 32'(v));
         idle(1);
      end
      chk("ovf_drained", 32'(word_valid), 32'd0);
      chk("ovf_sticky", 32'(overflow), 32'd1);

      // Reset mid-frame with two words queued.
      mode = 0;
      send_frame(4'h3, 0, 1'b0); idle(1);
      send_frame(4'h4, 0, 1'b0); idle(1);
      cyc(1'b1, 1'b1, 1'b1, 1, '0);
      cyc(1'b0, 1'b1, 1'b0, 1, '0);
      do_reset();
      chk_reset_state("midrst");
      send_frame(4'hA, 0, 1'b0);
      idle(1);
      chk("midrst_next_word", 32'(word_out), 32'hA);
      mode = 1;
      idle(1);

`ifdef RX_PARITY_EN
      mode = 0;
      send_frame(4'hD, 0, 1'b0);
      chk("par_ok_no_err", 32'(parity_err), 32'd0);
      idle(1);
      chk("par_ok_word", 32'(word_out), 32'hD);
      mode = 1;
      idle(1);
      mode = 0;
      send_frame(4'hD, 0, 1'b1);
      chk("par_bad_pulse", 32'(parity_err), 32'd1);
      chk("par_bad_busy", 32'(busy), 32'd0);
      idle(1);
      chk("par_bad_pulse_end", 32'(parity_err), 32'd0);
      chk("par_bad_no_push", 32'(word_valid), 32'd0);
`endif

      // Randomized frames, gaps, aborts and consumer backpressure.
      for (int n = 0; n < 40; n++) begin
         t    = $urandom;
         mode = int'(t % 3);
         if ((t[7:4] % 5) == 0) abort_bits(1 + int'(t[11:8] % (W - 1)));
         t    = $urandom;
         rw   = t[W-1:0];
         bad  = (PB == 1) && (t[9:8] == 2'b00);
         send_frame(rw, int'(t[13:12] % 3), bad);
         idle(1 + int'(t[17:16] % 3));
      end
      mode = 1;
      idle(DEPTH + 2);
      chk("final_drained", 32'(word_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/serial_word_rx.md
# serial_word_rx

Downstream receive stage for the parallel-in/serial-out shift register. Samples the serial bit stream `D` qualified by a bit-valid strobe and reassembles MSB-first frames of `WIDTH` bits into parallel words. Completed words are buffered in a small synchronous FIFO and handed to the consumer over a valid/ready handshake. Overflow is flagged sticky, and optional parity checking is available.

## Interface
- `WIDTH`, default 4: data bits per frame.
- `DEPTH`, default 4: output FIFO entries; must be a power of two, at least 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `D`  in  1: serial data bit, MSB first.
- `CS`  in  1: bit-valid; `D` is sampled only on edges where `CS`=1.
- `sof`  in  1: start of frame; meaningful only with `CS`=1; marks `D` as the frame MSB.
- `word_out`  out  WIDTH: FIFO head word.
- `word_valid`  out  1: FIFO not empty.
- `word_ready`  in  1: consumer pop; a pop occurs when `word_valid`&`word_ready`.
- `busy`  out  1: frame in progress, i.e. state ≠ IDLE.
- `overflow`  out  1: sticky; a completed word was dropped because the FIFO was full.
- `parity_err`  out  1: one-cycle pulse when a frame fails parity. Tied 0 without `RX_PARITY_EN`.

## Operation
- **FSM states:** IDLE, SHIFT, PAR (present only with the macro), PUSH.
- **IDLE:**
  - `CS`&`sof` loads `D` into shreg bit 0 and sets bitcnt=1.
  - Goes to SHIFT, or straight to PUSH when `WIDTH`=1.
  - `CS` without `sof` is ignored.
- **SHIFT:**
  - On each `CS`=1 edge: shreg ← {shreg[WIDTH-2:0], `D`} and bitcnt+1.
  - When bitcnt reaches `WIDTH`, go to PAR if enabled, else to PUSH.
  - `CS`=0 cycles are gaps: hold state and data.
- **Restart:** `CS`&`sof` while in SHIFT or PAR aborts the partial frame and restarts with `D` as the new MSB. No flag is raised.
- **PAR:** the next `CS`=1 bit is the even-parity bit. On a mismatch, pulse `parity_err` and return to IDLE without pushing.
- **PUSH:** unconditional one-cycle state. Writes shreg to the FIFO, then returns to IDLE. `CS`/`sof` arriving in PUSH are ignored, so an upstream must leave at least one gap cycle between frames.
- **FIFO full at push:**
  - Accepted if a pop occurs in the same cycle.
  - Otherwise the word is dropped and `overflow` is set.
  - `overflow` clears only on reset.
- **FIFO empty with `word_ready`=1:** no effect.
- **Ordering:** words leave in arrival order. `word_out` holds the head value while `word_valid`=1 and `word_ready`=0.

## Timing
- **Reset values:** state=IDLE, bitcnt=0, shreg=0, FIFO empty, `word_valid`=0, `word_out`=0, `busy`=0, `overflow`=0, `parity_err`=0.
- **Reset mid-frame:** discards the partial frame and all FIFO contents on the same edge.
- **Latency:** the last data bit (or the parity bit) is sampled at edge k. PUSH occupies cycle k→k+1, and `word_valid`=1 after edge k+1 (FIFO empty case).
- **Throughput:** one frame per `WIDTH`+1 cycles without parity, `WIDTH`+2 with parity, with `CS` continuous.
- **Pop:** takes effect on the edge; the next word is visible after that edge.
- **`parity_err`:** high for exactly the one cycle after the parity-bit edge.

## Configuration
- **`RX_PARITY_EN` defined:**
  - PAR state exists, and each frame carries `WIDTH`+1 bits.
  - Even parity: XOR of data and parity bits must equal 0.
  - Failing frames are discarded.
- **`RX_PARITY_EN` undefined:**
  - No PAR state, and frames are `WIDTH` bits.
  - `parity_err` is constant 0.

## Structure
- **Package `serial_rx_pkg`:** FSM state enum (`RX_IDLE`, `RX_SHIFT`, `RX_PAR`, `RX_PUSH`) and default `WIDTH`/`DEPTH` localparams.
- **Sub-module `rx_word_fifo`:** synchronous FIFO with parameters `WIDTH`/`DEPTH`, write/read pointers one bit wider than log2(`DEPTH`), and full/empty derived from the pointers. It provides wr_en/full and rd_en/empty.
- The top level contains the FSM, shreg, bitcnt and the `overflow` flag.

## Test plan
- **Single frame:** reset, then `CS`=1, `sof`=1 on first bit, bits 1,1,0,1 → `word_out`=4'hD, `word_valid`=1 one cycle after the PUSH cycle, `busy`=0 afterwards.
- **Gaps:** bits 0,0,1,0 with `CS`=0 gaps of 2 cycles between bits → `word_out`=4'h2, gaps add no extra bits.
- **Mid-frame restart:** send 1,0, then `sof` with 0,1,1,0 → only 4'h6 is pushed.
- **Backpressure and overflow:** `word_ready`=0, send 5 frames 4'h1–4'h5 with `DEPTH`=4 → FIFO holds 1,2,3,4, `overflow`=1. Then `word_ready`=1 → pops 1,2,3,4 in order, and `overflow` stays 1.
- **Reset mid-operation:** `rst_n`=0 for one edge mid-frame with 2 words queued → `word_valid`=0, `busy`=0. The next full frame 4'hA is received correctly.
- **Parity (`RX_PARITY_EN`):**
  - Frame 1,1,0,1 with parity 1 → 4'hD pushed.
  - Same frame with parity 0 → `parity_err` pulses once and no push occurs.
